debug_ctrl: RTL and testbench
=============================

DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter STEP_TIMEOUT, 16, max cycles STEPPING waits for core_retire before reporting error (range 1..255).
REQ-002 Parameter RESET_HALT, 0, 1 = core comes out of reset halted.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  debug command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  0 HALT, 1 RESUME, 2 STEP, 3 READ.
REQ-008 cmd_addr  input  6  READ target: 0-31 = x0-x31, 32 = PC, 33-63 illegal.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  response consumed.
REQ-011 rsp_data  output  32  response payload.
REQ-012 rsp_err  output  1  command rejected or failed.
REQ-013 core_stall  output  1  freezes PC update and regfile/memory writes of the core.
REQ-014 core_retire  input  1  core committed one instruction this cycle.
REQ-015 core_pc  input  32  current core PC.
REQ-016 dbg_rf_raddr  output  5  dedicated regfile debug read address.
REQ-017 dbg_rf_rdata  input  32  combinational regfile read data for dbg_rf_raddr.
REQ-018 halted  output  1  core held by controller (states HALTED, READING, or RESPOND-with-halt-flag set).

Function
REQ-019 FSM states SHALL be RUN, HALTED, STEPPING, READING, RESPOND; a halt flag SHALL record the idle state to return to after RESPOND.
REQ-020 cmd_ready SHALL be 1 only in RUN or HALTED; a command is accepted on cmd_valid && cmd_ready; every accepted command produces exactly one response.
REQ-021 core_stall SHALL be a combinational decode of state: 0 in RUN and STEPPING, 1 in HALTED, READING, and in RESPOND when halt flag = 1.
REQ-022 HALT: from RUN or HALTED -> RESPOND with halt flag = 1, rsp_data = core_pc sampled at accept, rsp_err = 0; core_stall = 1 from the following cycle.
REQ-023 RESUME: from RUN or HALTED -> RESPOND with halt flag = 0, rsp_data = 0, rsp_err = 0.
REQ-024 STEP in HALTED -> STEPPING; timeout counter cleared; exits STEPPING the cycle core_retire = 1 -> RESPOND, rsp_data = core_pc sampled the cycle after retire (next PC), rsp_err = 0, halt flag = 1.
REQ-025 STEPPING with no core_retire after STEP_TIMEOUT cycles -> RESPOND, rsp_err = 1, rsp_data = core_pc, halt flag = 1.
REQ-026 STEP in RUN -> RESPOND, rsp_err = 1, rsp_data = 0, no state change of core.
REQ-027 READ in HALTED with addr <= 31 -> READING for one cycle with dbg_rf_raddr = addr[4:0]; rsp_data = dbg_rf_rdata captured at end of that cycle, forced to 0 for addr 0.
REQ-028 READ addr 32 in HALTED -> RESPOND next cycle, rsp_data = core_pc; addr 33-63 or READ in RUN -> rsp_err = 1, rsp_data = 0.
REQ-029 Latency accept->rsp_valid: 1 cycle for HALT, RESUME, READ-PC, errors; 2 cycles for READ register; >= 2 for STEP.
REQ-030 RESPOND holds rsp_valid, rsp_data, rsp_err stable until rsp_ready; on handshake -> HALTED if halt flag else RUN; rsp_valid = 0 in every other state.
REQ-031 dbg_rf_raddr SHALL hold its last value outside READING.

Reset
REQ-032 On rst: state = HALTED if RESET_HALT else RUN; halt flag = RESET_HALT; rsp_valid = 0, rsp_data = 0, rsp_err = 0, dbg_rf_raddr = 0, timeout counter = 0; core_stall = RESET_HALT.
REQ-033 Reset during STEPPING, READING or RESPOND SHALL abandon the command with no response.

Structure
REQ-034 Package debug_pkg SHALL hold op encodings, FSM state enum, ADDR_PC = 32, and the response record type.
REQ-035 One sub-module dbg_step_timer (clear, enable, expired output, STEP_TIMEOUT parameter) SHALL implement the timeout counter.

Verification
REQ-036 RESET_HALT = 0, HALT with core_pc = 0x00000010 -> rsp_valid 1 cycle later, rsp_data = 0x00000010, core_stall = 1, PC frozen thereafter.
REQ-037 Halted, STEP -> exactly one core_retire pulse, PC advances 4, rsp_data = old PC + 4, core_stall = 1 again.
REQ-038 Halted, x1 = 0x00000005, READ addr 1 -> rsp_data = 0x00000005 two cycles after accept; READ addr 0 -> 0x00000000; READ addr 40 -> rsp_err = 1.
REQ-039 STEP with core_retire tied 0, STEP_TIMEOUT = 16 -> rsp_err = 1 after 16 STEPPING cycles, halted = 1.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready = 0; rst asserted mid-RESPOND -> rsp_valid = 0 immediately, state = RUN.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller: command opcodes, FSM states,
// the READ address of the PC, and the registered response record.
package debug_pkg;

    typedef enum logic [1:0] {
        OP_HALT   = 2'd0,
        OP_RESUME = 2'd1,
        OP_STEP   = 2'd2,
        OP_READ   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_HALTED   = 3'd1,
        ST_STEPPING = 3'd2,
        ST_READING  = 3'd3,
        ST_RESPOND  = 3'd4
    } state_e;

    // READ addresses 0..31 select x0..x31, 32 selects the PC, above is illegal.
    localparam logic [5:0] ADDR_PC = 6'd32;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

endpackage

// File: rtl/dbg_step_timer.sv
// Single-step watchdog. Counts cycles spent stepping; expired_o flags the
// last permitted cycle so the controller leaves STEPPING after exactly
// STEP_TIMEOUT cycles without a retire.
module dbg_step_timer #(
    parameter int unsigned STEP_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LAST_CYCLE = 8'(STEP_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear wins, otherwise count enabled cycles and saturate.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST_CYCLE)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LAST_CYCLE);

endmodule

// File: rtl/debug_ctrl.sv
// Debug controller: accepts HALT / RESUME / STEP / READ commands over a
// valid/ready pair, stalls the core while halted, and returns exactly one
// registered response per accepted command.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. cmd_ready depends only on state (never on cmd_valid); once
// rsp_valid rises, rsp_valid/rsp_data/rsp_err hold until rsp_ready.
module debug_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned STEP_TIMEOUT = 16,
    parameter bit          RESET_HALT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        core_stall,
    input  logic        core_retire,
    input  logic [31:0] core_pc,
    output logic [4:0]  dbg_rf_raddr,
    input  logic [31:0] dbg_rf_rdata,
    output logic        halted,
    output logic [2:0]  dbg_state
);

    localparam state_e RESET_STATE = RESET_HALT ? ST_HALTED : ST_RUN;

    state_e     state_q, state_d;
    logic       halt_q, halt_d;     // idle state to return to after RESPOND
    logic       pend_q, pend_d;     // step finished, PC not yet captured
    rsp_t       rsp_q, rsp_d;
    logic [4:0] raddr_q, raddr_d;

    logic       tmr_clear;
    logic       tmr_expired;
    logic       stall;

    dbg_step_timer #(
        .STEP_TIMEOUT(STEP_TIMEOUT)
    ) u_step_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (state_q == ST_STEPPING),
        .expired_o (tmr_expired)
    );

    // Next-state and response logic for the command FSM.
    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        pend_d    = pend_q;
        rsp_d     = rsp_q;
        raddr_d   = raddr_q;
        tmr_clear = 1'b0;

        case (state_q)
            ST_RUN, ST_HALTED: begin
                if (cmd_valid) begin
                    // Default outcome: immediate response, core state unchanged.
                    state_d = ST_RESPOND;
                    halt_d  = (state_q == ST_HALTED);
                    rsp_d   = '0;
                    case (op_e'(cmd_op))
                        OP_HALT: begin
                            halt_d     = 1'b1;
                            rsp_d.data = core_pc;
                        end
                        OP_RESUME: begin
                            halt_d = 1'b0;
                        end
                        OP_STEP: begin
                            if (state_q == ST_HALTED) begin
                                state_d   = ST_STEPPING;
                                tmr_clear = 1'b1;
                            end else begin
                                rsp_d.err = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (state_q != ST_HALTED) begin
                                rsp_d.err = 1'b1;
                            end else if (cmd_addr < ADDR_PC) begin
                                state_d = ST_READING;
                                raddr_d = cmd_addr[4:0];
                            end else if (cmd_addr == ADDR_PC) begin
                                rsp_d.data = core_pc;
                            end else begin
                                rsp_d.err = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_STEPPING: begin
                // A retire in the final permitted cycle still counts as success.
                if (core_retire) begin
                    state_d   = ST_RESPOND;
                    pend_d    = 1'b1;
                    rsp_d.err = 1'b0;
                end else if (tmr_expired) begin
                    state_d   = ST_RESPOND;
                    pend_d    = 1'b1;
                    rsp_d.err = 1'b1;
                end
            end

            ST_READING: begin
                rsp_d.err  = 1'b0;
                rsp_d.data = (raddr_q == 5'd0) ? 32'd0 : dbg_rf_rdata;
                state_d    = ST_RESPOND;
            end

            ST_RESPOND: begin
                if (pend_q) begin
                    // Core is stalled now, so core_pc already shows the next PC.
                    pend_d     = 1'b0;
                    rsp_d.data = core_pc;
                end else if (rsp_ready) begin
                    state_d = halt_q ? ST_HALTED : ST_RUN;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            halt_q  <= RESET_HALT;
            pend_q  <= 1'b0;
            rsp_q   <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            pend_q  <= pend_d;
            rsp_q   <= rsp_d;
            raddr_q <= raddr_d;
        end
    end

    assign stall = (state_q == ST_HALTED) || (state_q == ST_READING) ||
                   ((state_q == ST_RESPOND) && halt_q);

    assign cmd_ready    = (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign rsp_valid    = (state_q == ST_RESPOND) && !pend_q;
    assign rsp_data     = rsp_q.data;
    assign rsp_err      = rsp_q.err;
    assign core_stall   = stall;
    assign halted       = stall;
    assign dbg_rf_raddr = raddr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: a core/regfile model, a command driver with a
// behavioural reference model, and a monitor that pops expected responses.
module tb_debug_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        core_stall;
  logic        core_retire;
  logic [31:0] core_pc;
  logic [4:0]  dbg_rf_raddr;
  logic [31:0] dbg_rf_rdata;
  logic        halted;
  logic [2:0]  dbg_state;

  debug_ctrl #(
    .STEP_TIMEOUT(T),
    .RESET_HALT(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_stall(core_stall), .core_retire(core_retire), .core_pc(core_pc),
    .dbg_rf_raddr(dbg_rf_raddr), .dbg_rf_rdata(dbg_rf_rdata),
    .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];          // {err, data}

  // reference model state
  bit         model_halted = 1'b0;
  logic [4:0] last_raddr = 5'd0;
  logic [31:0] rf [32];

  // environment controls
  int  rdy_mode  = 2;             // 0 never ready, 1 random, 2 always
  bit  free_run  = 1'b0;
  bit  step_mode = 1'b0;
  int  step_delay = 0;            // running cycles before the stepped retire
  int  step_low  = 0;             // unstalled cycles seen during a step
  int  step_ret  = 0;             // retires seen during a step

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  assign dbg_rf_rdata = rf[dbg_rf_raddr];

  // ---------------- core + response-ready model ----------------
  always @(negedge clk) begin
    if (rst) begin
      core_retire = 1'b0;
    end else begin
      if (core_retire) core_pc = core_pc + 32'd4;
      if (core_stall) begin
        core_retire = 1'b0;
      end else if (step_mode) begin
        core_retire = (step_low == step_delay);
        if (core_retire) step_ret++;
        step_low++;
      end else begin
        core_retire = free_run && ($urandom_range(0, 1) == 1);
      end
    end
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b1;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  bit          hold = 1'b0;
  logic [32:0] held;
  always @(negedge clk) begin
    logic [32:0] e;
    #3;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) check("rsp_stable", {31'd0, rsp_valid, rsp_err, rsp_data}, {31'd0, 1'b1, held});
      if (rsp_valid && !rsp_ready) begin
        hold = 1'b1;
        held = {rsp_err, rsp_data};
      end else begin
        hold = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {31'd0, rsp_err, rsp_data}, {31'd0, e});
        end
      end
    end
  end

  // ---------------- driver with reference model ----------------
  task automatic issue(input logic [1:0] op, input logic [5:0] addr);
    logic [32:0] e;
    int exp_lat;
    int lat;
    int g;
    bit is_step;
    bit ok;
    g = 0;
    @(negedge clk); #1;
    while (!cmd_ready && g < 300) begin
      @(negedge clk); #1;
      g++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 64'd0, 64'd1);
      return;
    end
    check("idle_stall", {63'd0, core_stall}, {63'd0, model_halted});
    check("idle_halted", {63'd0, halted}, {63'd0, model_halted});
    check("idle_raddr", {59'd0, dbg_rf_raddr}, {59'd0, last_raddr});

    is_step = 1'b0;
    ok = 1'b0;
    exp_lat = 1;
    e = '0;
    case (op)
      2'd0: begin
        e = {1'b0, core_pc};
        model_halted = 1'b1;
      end
      2'd1: begin
        e = '0;
        model_halted = 1'b0;
      end
      2'd2: begin
        if (!model_halted) begin
          e = {1'b1, 32'd0};
        end else begin
          is_step = 1'b1;
          ok = (step_delay < T);
          e = ok ? {1'b0, core_pc + 32'd4} : {1'b1, core_pc};
          step_low = 0;
          step_ret = 0;
          step_mode = 1'b1;
        end
      end
      default: begin
        if (!model_halted || addr > 6'd32) begin
          e = {1'b1, 32'd0};
        end else if (addr == 6'd32) begin
          e = {1'b0, core_pc};
        end else begin
          e = {1'b0, (addr == 6'd0) ? 32'd0 : rf[addr[4:0]]};
          exp_lat = 2;
          last_raddr = addr[4:0];
        end
      end
    endcase
    exp_q.push_back(e);

    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = addr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_addr = 6'($urandom_range(0, 63));

    lat = 0;
    do begin
      @(negedge clk); #2;
      lat++;
    end while (!rsp_valid && lat < 80);

    if (is_step) begin
      check("step_rsp_seen", {63'd0, rsp_valid}, 64'd1);
      check("step_lat_min2", {63'd0, (lat >= 2)}, 64'd1);
      check("step_run_cycles", 64'(step_low), 64'(ok ? step_delay + 1 : T));
      check("step_retires", 64'(step_ret), 64'(ok ? 1 : 0));
      check("step_halted", {63'd0, halted}, 64'd1);
      step_mode = 1'b0;
    end else begin
      check("rsp_latency", 64'(lat), 64'(exp_lat));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] pc_at;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_addr = 6'd0;
    rsp_ready = 1'b1;
    core_retire = 1'b0;
    core_pc = 32'h0000_0010;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hdead_beef;
    rf[1] = 32'h0000_0005;

    repeat (3) @(negedge clk);
    #2;
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("reset_core_stall", {63'd0, core_stall}, 64'd0);
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("reset_raddr", {59'd0, dbg_rf_raddr}, 64'd0);
    check("reset_state_run", {61'd0, dbg_state}, 64'd0);
    #1 rst = 1'b0;

    // halt at PC 0x10, register / PC reads, illegal read
    issue(2'd0, 6'd0);
    issue(2'd3, 6'd1);
    issue(2'd3, 6'd0);
    issue(2'd3, 6'd40);
    issue(2'd3, 6'd32);

    // successful step, then a step whose retire never arrives
    step_delay = 2;
    issue(2'd2, 6'd0);
    step_delay = 1000;
    issue(2'd2, 6'd0);

    // commands that are errors while running
    issue(2'd1, 6'd0);
    issue(2'd2, 6'd0);
    issue(2'd3, 6'd1);
    issue(2'd3, 6'd32);

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      rdy_mode = $urandom_range(1, 2);
      free_run = 1'($urandom_range(0, 1));
      step_delay = $urandom_range(0, T + 4);
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       addr = 6'd32;
        1:       addr = 6'($urandom_range(33, 63));
        default: addr = 6'($urandom_range(0, 31));
      endcase
      issue(op, addr);
    end

    // response held off, then reset in the middle of RESPOND
    rdy_mode = 2;
    issue(2'd1, 6'd0);
    free_run = 1'b0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    #1 pc_at = core_pc;
    issue(2'd0, 6'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_data", {32'd0, rsp_data}, {32'd0, pc_at});
      check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_mid_state_run", {61'd0, dbg_state}, 64'd0);
    check("rst_mid_stall", {63'd0, core_stall}, 64'd0);
    exp_q.delete();
    model_halted = 1'b0;
    last_raddr = 5'd0;
    rdy_mode = 2;
    @(negedge clk); #1;
    rst = 1'b0;

    // one more command after reset to confirm the controller is alive
    issue(2'd0, 6'd0);

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    #4;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
